// File: rtl/conv_addr_gen.sv
// conv_addr_gen: nested-loop PE buffer read address generator; optional multi-pass repeat under CONV_AGEN_REPEAT_EN
module conv_addr_gen #(
   parameter int ADDR_W     = 13,
   parameter int CNT_W      = 8,
   parameter int NUM_LEVELS = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [ADDR_W-1:0]            cfg_base,
   input  logic [NUM_LEVELS*CNT_W-1:0]  cfg_bound,
   input  logic [NUM_LEVELS*ADDR_W-1:0] cfg_stride,
`ifdef CONV_AGEN_REPEAT_EN
   input  logic [CNT_W-1:0]             cfg_repeat,
`endif
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ADDR_W-1:0]            out_addr,
   output logic                         out_last,
   output logic                         busy,
   output logic                         done
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [CNT_W-1:0] cnt [NUM_LEVELS];
   logic [CNT_W-1:0] bnd [NUM_LEVELS];
   logic [CNT_W-1:0] nxt_cnt [NUM_LEVELS];
   logic [CNT_W-1:0] cfg_bnd [NUM_LEVELS];
   logic [ADDR_W-1:0] strd [NUM_LEVELS];
   logic [ADDR_W-1:0] base_q, step;
   logic [NUM_LEVELS-1:0] at_end, nxt_end, cfg_one;
   logic all_end, more, start_final, restart_final, hs;
   assign hs = out_valid & out_ready;
`ifdef CONV_AGEN_REPEAT_EN
   logic [CNT_W-1:0] rep_q, pass_q;
   assign more = pass_q != rep_q;
   assign start_final = cfg_repeat == '0;
   assign restart_final = pass_q + CNT_W'(1) == rep_q;
   // count completed passes so only the final one flags last/done
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pass_q <= '0;
         rep_q <= '0;
      end else if (abort) begin
         pass_q <= '0;
      end else if (state == IDLE && start) begin
         pass_q <= '0;
         rep_q <= cfg_repeat;
      end else if (hs && all_end && more) begin
         pass_q <= pass_q + CNT_W'(1);
      end
   end
`else
   assign more = 1'b0;
   assign start_final = 1'b1;
   assign restart_final = 1'b0;
`endif
   // odometer: lowest non-final level steps, lower levels wrap to 0
   always_comb begin
      step = '0;
      for (int i = NUM_LEVELS-1; i >= 0; i--) begin
         cfg_bnd[i] = cfg_bound[i*CNT_W +: CNT_W] == '0 ? CNT_W'(1) : cfg_bound[i*CNT_W +: CNT_W];
         cfg_one[i] = cfg_bnd[i] == CNT_W'(1);
         at_end[i] = cnt[i] == bnd[i] - CNT_W'(1);
         if (!at_end[i]) step = strd[i];
      end
      all_end = 1'b1;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         nxt_cnt[i] = !all_end ? cnt[i] : at_end[i] ? '0 : cnt[i] + CNT_W'(1);
         nxt_end[i] = nxt_cnt[i] == bnd[i] - CNT_W'(1);
         all_end = all_end & at_end[i];
      end
   end
   // pass sequencing, loop counters and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         out_valid <= 1'b0;
         out_addr <= '0;
         out_last <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         base_q <= '0;
         for (int i = 0; i < NUM_LEVELS; i++) begin
            cnt[i] <= '0;
            bnd[i] <= '0;
            strd[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            busy <= 1'b0;
         end else if (state == IDLE) begin
            if (start) begin
               state <= RUN;
               out_valid <= 1'b1;
               busy <= 1'b1;
               out_addr <= cfg_base;
               base_q <= cfg_base;
               out_last <= (&cfg_one) & start_final;
               for (int i = 0; i < NUM_LEVELS; i++) begin
                  cnt[i] <= '0;
                  bnd[i] <= cfg_bnd[i];
                  strd[i] <= cfg_stride[i*ADDR_W +: ADDR_W];
               end
            end
         end else if (hs) begin
            if (all_end && !more) begin
               state <= IDLE;
               out_valid <= 1'b0;
               out_last <= 1'b0;
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               for (int i = 0; i < NUM_LEVELS; i++) cnt[i] <= nxt_cnt[i];
               out_addr <= all_end ? base_q : out_addr + step;
               out_last <= (&nxt_end) & (all_end ? restart_final : !more);
            end
         end
      end
   end
endmodule
